// File: rtl/line_sequencer_if.sv
// line_sequencer_if
//   Bundles the line-memory read port and the Controller/Datapath handshake
//   that the line sequencer drives.
//   Signals:
//     mem_ren    sequencer -> memory      read enable
//     mem_addr   sequencer -> memory      read address
//     mem_rdata  memory    -> sequencer   read data, valid one cycle after mem_ren
//     line       sequencer -> Controller  current instruction line
//     start      sequencer -> Controller  one-cycle pulse per line
//     done       Datapath  -> sequencer   line-complete flag
//   Modports: master (sequencer side), slave (memory / Controller side).
interface line_sequencer_if #(
    parameter int LINE_W = 25,
    parameter int ADDR_W = 6
);
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_rdata;
    logic [LINE_W-1:0] line;
    logic              start;
    logic              done;

    modport master (
        output mem_ren,
        output mem_addr,
        output line,
        output start,
        input  mem_rdata,
        input  done
    );

    modport slave (
        input  mem_ren,
        input  mem_addr,
        input  line,
        input  start,
        output mem_rdata,
        output done
    );
endinterface

// File: rtl/line_sequencer.sv
// line_sequencer
//   Walks the line memory from address 0, presents each line to the
//   Controller, pulses start, and waits for done before moving on. A run ends
//   on the EOF sentinel line, after the last memory entry, on a watchdog
//   expiry (sticky err, parks in ERR) or on abort.
//   Ports:
//     clk, rst     clock (rising edge) and asynchronous active-high reset
//     go           level; starts a run from address 0 when seen in IDLE
//     abort        synchronous return to IDLE from any state
//     bus          line_sequencer_if.master: memory read port + start/done
//     busy         high in every state except IDLE
//     finished     sticky; run ended normally (EOF or end of memory)
//     err          sticky; watchdog expired waiting for done
//     line_count   lines completed in the current run (0..DEPTH)
module line_sequencer #(
    parameter int               LINE_W  = 25,
    parameter int               DEPTH   = 64,
    parameter int               ADDR_W  = 6,
    parameter logic [LINE_W-1:0] EOF_VAL = 25'h1FF_FFFF,
    parameter int               TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               abort,
    line_sequencer_if.master   bus,
    output logic               busy,
    output logic               finished,
    output logic               err,
    output logic [ADDR_W:0]    line_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RDWAIT,
        S_ISSUE,
        S_RUN,
        S_FIN,
        S_ERR
    } state_t;

    state_t              state_q,      state_d;
    logic                mem_ren_q,    mem_ren_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [LINE_W-1:0]   line_q,       line_d;
    logic                start_q,      start_d;
    logic                busy_q,       busy_d;
    logic                finished_q,   finished_d;
    logic                err_q,        err_d;
    logic [ADDR_W:0]     line_count_q, line_count_d;
    logic [WD_W-1:0]     wd_q,         wd_d;

    // Every output is a flop. Pulse outputs (mem_ren, start) and the sticky
    // flags are computed for the state being entered, so they are high
    // exactly while the FSM sits in FETCH / ISSUE / FIN / ERR.
    always_comb begin
        state_d      = state_q;
        mem_ren_d    = 1'b0;
        start_d      = 1'b0;
        mem_addr_d   = mem_addr_q;
        line_d       = line_q;
        finished_d   = finished_q;
        err_d        = err_q;
        line_count_d = line_count_q;
        wd_d         = wd_q;

        if (abort) begin
            // Abort overrides everything; status and the last line are kept.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        finished_d   = 1'b0;
                        err_d        = 1'b0;
                        line_count_d = '0;
                        mem_addr_d   = '0;
                        mem_ren_d    = 1'b1;
                        state_d      = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_RDWAIT;
                end
                S_RDWAIT: begin
                    // The sentinel itself is never presented on line.
                    if (bus.mem_rdata == EOF_VAL) begin
                        finished_d = 1'b1;
                        state_d    = S_FIN;
                    end else begin
                        line_d  = bus.mem_rdata;
                        start_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_d    = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // done is checked before the watchdog so a completion in
                    // the final allowed cycle still counts.
                    if (bus.done) begin
                        line_count_d = line_count_q + CNT_ONE;
                        if (mem_addr_q == LAST_ADDR) begin
                            finished_d = 1'b1;
                            state_d    = S_FIN;
                        end else begin
                            mem_addr_d = mem_addr_q + ADDR_ONE;
                            mem_ren_d  = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end else if (wd_q == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        wd_d = wd_q + WD_ONE;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_ren_q    <= 1'b0;
            mem_addr_q   <= '0;
            line_q       <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            err_q        <= 1'b0;
            line_count_q <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            mem_ren_q    <= mem_ren_d;
            mem_addr_q   <= mem_addr_d;
            line_q       <= line_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            err_q        <= err_d;
            line_count_q <= line_count_d;
            wd_q         <= wd_d;
        end
    end

    assign bus.mem_ren  = mem_ren_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.line     = line_q;
    assign bus.start    = start_q;
    assign busy         = busy_q;
    assign finished     = finished_q;
    assign err          = err_q;
    assign line_count   = line_count_q;

endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer
//   Directed bench for line_sequencer with TIMEOUT=10. A behavioural line
//   memory answers reads one cycle after mem_ren; a Datapath stand-in raises
//   done a programmable number of cycles after each start pulse.
module tb_line_sequencer;

    localparam int LW = 25;
    localparam int AW = 6;
    localparam logic [LW-1:0] EOF_V = 25'h1FF_FFFF;

    logic clk;
    logic rst;
    logic go;
    logic abort;
    logic busy;
    logic finished;
    logic err;
    logic [AW:0] line_count;

    line_sequencer_if #(.LINE_W(LW), .ADDR_W(AW)) bif ();

    line_sequencer #(
        .LINE_W (LW),
        .DEPTH  (64),
        .ADDR_W (AW),
        .EOF_VAL(EOF_V),
        .TIMEOUT(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .abort     (abort),
        .bus       (bif),
        .busy      (busy),
        .finished  (finished),
        .err       (err),
        .line_count(line_count)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line memory with registered read.
    logic [LW-1:0] mem [64];
    always @(posedge clk) begin
        if (bif.mem_ren) bif.mem_rdata <= mem[bif.mem_addr];
    end

    // done = automatic responder OR manual pulse from a test.
    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    int   done_delay = 0;   // 0 = responder disabled
    int   dcnt = 0;
    assign bif.done = auto_done | man_done;

    always @(negedge clk) begin
        if (rst) begin
            dcnt      <= 0;
            auto_done <= 1'b0;
        end else begin
            auto_done <= 1'b0;
            if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) auto_done <= 1'b1;
            end
            if (bif.start && done_delay > 0) dcnt <= done_delay;
        end
    end

    // Transaction monitor: one line per start pulse.
    int start_cnt = 0;
    int ren_cnt = 0;
    logic [LW-1:0] line_log [$];
    always @(negedge clk) begin
        if (bif.mem_ren) ren_cnt <= ren_cnt + 1;
        if (bif.start) begin
            start_cnt <= start_cnt + 1;
            line_log.push_back(bif.line);
            $display("start: line=%07h count=%0d addr=%0d", bif.line, line_count, bif.mem_addr);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic start_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_start(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bif.start) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished: got %0b expected 0", finished); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (line_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", line_count); end
        checks++; if (bif.mem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %0b expected 0", bif.mem_ren); end
        checks++; if (bif.start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", bif.start); end
        checks++; if (bif.mem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bif.mem_addr); end
        checks++; if (bif.line !== 25'd0) begin errors++; $display("FAIL reset_line: got %0h expected 0", bif.line); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_eof_first();
        bit to;
        int s0;
        mem[0] = EOF_V;
        done_delay = 1;
        s0 = start_cnt;
        start_go();
        wait_idle(50, to);
        checks++; if (to) begin errors++; $display("FAIL eof_idle: got timeout expected idle"); end
        checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL eof_starts: got %0d expected 0", start_cnt - s0); end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL eof_finished: got %0b expected 1", finished); end
        checks++; if (line_count !== 7'd0) begin errors++; $display("FAIL eof_count: got %0d expected 0", line_count); end
        checks++; if (bif.line !== 25'd0) begin errors++; $display("FAIL eof_line: got %0h expected 0", bif.line); end
    endtask

    task automatic test_normal();
        bit to;
        int s0;
        int lb;
        mem[0] = 25'h0000123;
        mem[1] = 25'h1ABCDEF;
        mem[2] = 25'h0F0F0F0;
        mem[3] = EOF_V;
        done_delay = 5;
        s0 = start_cnt;
        lb = line_log.size();
        start_go();
        wait_idle(200, to);
        checks++; if (to) begin errors++; $display("FAIL normal_idle: got timeout expected idle"); end
        checks++; if (start_cnt - s0 !== 3) begin errors++; $display("FAIL normal_starts: got %0d expected 3", start_cnt - s0); end
        for (int i = 0; i < 3; i++) begin
            if (line_log.size() > lb + i) begin
                checks++;
                if (line_log[lb+i] !== mem[i]) begin errors++; $display("FAIL normal_line%0d: got %07h expected %07h", i, line_log[lb+i], mem[i]); end
            end
        end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL normal_finished: got %0b expected 1", finished); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL normal_err: got %0b expected 0", err); end
        checks++; if (line_count !== 7'd3) begin errors++; $display("FAIL normal_count: got %0d expected 3", line_count); end
        checks++; if (bif.line !== 25'h0F0F0F0) begin errors++; $display("FAIL normal_line_after_eof: got %07h expected 0f0f0f0", bif.line); end
    endtask

    task automatic test_full_memory();
        bit to;
        int s0;
        int r0;
        for (int i = 0; i < 64; i++) mem[i] = 25'h0010000 + 25'(i);
        done_delay = 1;
        s0 = start_cnt;
        r0 = ren_cnt;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        checks++; if (finished !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_go_clears: got finished=%0b busy=%0b expected 0/1", finished, busy); end
        wait_idle(400, to);
        checks++; if (to) begin errors++; $display("FAIL full_idle: got timeout expected idle"); end
        checks++; if (start_cnt - s0 !== 64) begin errors++; $display("FAIL full_starts: got %0d expected 64", start_cnt - s0); end
        checks++; if (ren_cnt - r0 !== 64) begin errors++; $display("FAIL full_reads: got %0d expected 64", ren_cnt - r0); end
        checks++; if (line_count !== 7'd64) begin errors++; $display("FAIL full_count: got %0d expected 64", line_count); end
        checks++; if (bif.mem_addr !== 6'd63) begin errors++; $display("FAIL full_addr: got %0d expected 63", bif.mem_addr); end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL full_finished: got %0b expected 1", finished); end
        checks++; if (bif.line !== 25'h001003F) begin errors++; $display("FAIL full_last_line: got %07h expected 001003f", bif.line); end
    endtask

    task automatic test_watchdog();
        bit to;
        int r0;
        mem[0] = 25'h0000AAA;
        mem[1] = EOF_V;
        done_delay = 0;
        start_go();
        wait_start(20, to);
        checks++; if (to) begin errors++; $display("FAIL wd_start: got timeout expected start"); end
        // Ten RUN cycles without done; err must still be low at the tenth.
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 10) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_early: got err=%0b expected 0 after %0d cycles", err, i); end
            end
        end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_expire: got err=%0b expected 1", err); end
        r0 = ren_cnt;
        repeat (5) @(negedge clk);
        checks++; if (ren_cnt !== r0) begin errors++; $display("FAIL wd_no_fetch: got %0d reads expected %0d", ren_cnt, r0); end
        checks++; if (busy !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL wd_hold: got busy=%0b err=%0b expected 1/1", busy, err); end
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        checks++; if (busy !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL wd_abort: got busy=%0b err=%0b expected 0/1", busy, err); end
        done_delay = 2;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd_go_clears: got err=%0b busy=%0b expected 0/1", err, busy); end
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL wd_rerun_idle: got timeout expected idle"); end
        checks++; if (line_count !== 7'd1 || finished !== 1'b1) begin errors++; $display("FAIL wd_rerun: got count=%0d finished=%0b expected 1/1", line_count, finished); end
    endtask

    task automatic test_done_in_issue();
        bit to;
        mem[0] = 25'h0000BBB;
        mem[1] = EOF_V;
        done_delay = 0;
        start_go();
        wait_start(20, to);
        checks++; if (to) begin errors++; $display("FAIL issue_start: got timeout expected start"); end
        man_done = 1'b1;
        @(negedge clk) man_done = 1'b0;
        checks++; if (line_count !== 7'd0 || busy !== 1'b1) begin errors++; $display("FAIL issue_done_ignored: got count=%0d busy=%0b expected 0/1", line_count, busy); end
        repeat (2) @(negedge clk);
        checks++; if (line_count !== 7'd0) begin errors++; $display("FAIL issue_done_not_latched: got %0d expected 0", line_count); end
        man_done = 1'b1;
        @(negedge clk) man_done = 1'b0;
        checks++; if (line_count !== 7'd1) begin errors++; $display("FAIL issue_real_done: got %0d expected 1", line_count); end
        wait_idle(50, to);
        checks++; if (to || finished !== 1'b1) begin errors++; $display("FAIL issue_finish: got timeout=%0b finished=%0b expected 0/1", to, finished); end
    endtask

    task automatic test_done_at_expiry();
        bit to;
        mem[0] = 25'h0000CCC;
        mem[1] = EOF_V;
        done_delay = 10;   // done lands in the tenth RUN cycle, the expiry cycle
        start_go();
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL expiry_idle: got timeout expected idle"); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL expiry_err: got %0b expected 0", err); end
        checks++; if (line_count !== 7'd1) begin errors++; $display("FAIL expiry_count: got %0d expected 1", line_count); end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL expiry_finished: got %0b expected 1", finished); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int s0;
        int r0;
        for (int i = 0; i < 4; i++) mem[i] = 25'h0002000 + 25'(i);
        mem[4] = EOF_V;
        done_delay = 5;
        start_go();
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge clk);
            if (bif.start) n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL rstmid_reach: got %0d starts expected 3", n); end
        @(negedge clk);
        checks++; if (line_count !== 7'd2 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got count=%0d busy=%0b expected 2/1", line_count, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
        checks++; if (line_count !== 7'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", line_count); end
        checks++; if (bif.line !== 25'd0) begin errors++; $display("FAIL rstmid_line: got %07h expected 0", bif.line); end
        checks++; if (bif.mem_addr !== 6'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", bif.mem_addr); end
        checks++; if (bif.start !== 1'b0 || bif.mem_ren !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got start=%0b ren=%0b expected 0/0", bif.start, bif.mem_ren); end
        checks++; if (finished !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got finished=%0b err=%0b expected 0/0", finished, err); end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        s0 = start_cnt;
        r0 = ren_cnt;
        repeat (20) @(negedge clk);
        checks++; if (start_cnt !== s0 || ren_cnt !== r0) begin errors++; $display("FAIL rstmid_quiet: got starts+%0d reads+%0d expected 0/0", start_cnt - s0, ren_cnt - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%0b expected 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_eof_first();
        test_normal();
        test_full_memory();
        test_watchdog();
        test_done_in_issue();
        test_done_at_expiry();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
